// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the
// float-to-int conversion unit.
package fpu_pkg;

    localparam logic [7:0]  EXP_BIAS     = 8'd127;
    localparam int          FRAC_W       = 23;
    localparam logic [7:0]  EXP_MAX      = 8'd255;
    localparam logic [31:0] INT_MAX      = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;
    localparam logic [4:0]  RSHIFT_CLAMP = 5'd25;

    // Exponent at which the 24-bit significand is already an integer.
    localparam logic [7:0]  SHIFT_EXP    = EXP_BIAS + 8'(FRAC_W);
    // First exponent whose magnitude reaches 2^31.
    localparam logic [7:0]  OVF_EXP      = EXP_BIAS + 8'd31;
    // -2^31 as binary32: the only representable value at OVF_EXP.
    localparam logic [31:0] F32_INT_MIN  = 32'hCF00_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/ftoi_if.sv
// Operand/result handshake bundle for ftoi.
// master drives operands and consumes results.
interface ftoi_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        ovf;

    modport master (
        output in_valid,
        output a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res,
        output ovf
    );

endinterface

// File: rtl/ftoi_classify.sv
// Decodes a binary32 operand into its special case
// flags, shift direction and shift distance.
module ftoi_classify
    import fpu_pkg::*;
(
    input  logic [31:0] i_a,
    output logic        o_is_nan,
    output logic        o_is_inf,
    output logic        o_is_ovf,
    output logic        o_is_exact_min,
    output logic        o_dir_left,
    output logic [4:0]  o_count
);

    logic [7:0]        w_e;
    logic [FRAC_W-1:0] w_frac;
    logic              w_big;
    logic [4:0]        w_ldist;
    logic [7:0]        w_rdist;

    assign w_e    = i_a[30:23];
    assign w_frac = i_a[FRAC_W-1:0];
    assign w_big  = (w_e >= OVF_EXP);

    assign o_is_nan       = (w_e == EXP_MAX) && (w_frac != '0);
    assign o_is_inf       = (w_e == EXP_MAX) && (w_frac == '0);
    assign o_is_exact_min = (i_a == F32_INT_MIN);
    assign o_is_ovf       = w_big && (w_e != EXP_MAX)
                          && !o_is_exact_min;
    assign o_dir_left     = (w_e >= SHIFT_EXP);

    assign w_ldist = 5'(w_e - SHIFT_EXP);
    assign w_rdist = SHIFT_EXP - w_e;

    // Shift distance; special cases need no shifting.
    always_comb begin
        o_count = '0;
        if (w_big) begin
            o_count = '0;
        end else if (o_dir_left) begin
            o_count = w_ldist;
        end else if (w_rdist > {3'd0, RSHIFT_CLAMP}) begin
            o_count = RSHIFT_CLAMP;
        end else begin
            o_count = 5'(w_rdist);
        end
    end

endmodule

// File: rtl/ftoi.sv
// Serial binary32 to int32 converter: one shift per
// cycle, round-to-nearest-even, saturating on overflow.
module ftoi
    import fpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    ftoi_if.slave bus
);

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_res;
    logic        r_ovf;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [4:0]  r_count;
    logic        r_left;
    logic        r_guard;
    logic        r_sticky;
    logic        r_spec;
    logic [31:0] r_spec_res;
    logic        r_spec_ovf;

    logic        w_is_nan;
    logic        w_is_inf;
    logic        w_is_ovf;
    logic        w_is_exact_min;
    logic        w_dir_left;
    logic [4:0]  w_count;
    logic [23:0] w_m;
    logic        w_accept;
    logic        w_spec;
    logic [31:0] w_spec_res;
    logic        w_up;
    logic [31:0] w_rounded;
    logic [31:0] w_signed;

    ftoi_classify u_classify (
        .i_a            (bus.a),
        .o_is_nan       (w_is_nan),
        .o_is_inf       (w_is_inf),
        .o_is_ovf       (w_is_ovf),
        .o_is_exact_min (w_is_exact_min),
        .o_dir_left     (w_dir_left),
        .o_count        (w_count)
    );

    assign w_m      = {(bus.a[30:23] != 8'd0), bus.a[FRAC_W-1:0]};
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_spec   = w_is_nan || w_is_inf
                    || w_is_ovf || w_is_exact_min;

    // Saturation value for the special cases.
    always_comb begin
        w_spec_res = INT_MIN;
        if (w_is_nan || w_is_exact_min) begin
            w_spec_res = INT_MIN;
        end else if (bus.a[31]) begin
            w_spec_res = INT_MIN;
        end else begin
            w_spec_res = INT_MAX;
        end
    end

    assign w_up      = r_guard && (r_sticky || r_mag[0]);
    assign w_rounded = r_mag + {31'd0, w_up};
    assign w_signed  = r_sign ? (~w_rounded + 32'd1) : w_rounded;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_count     <= '0;
            r_left      <= 1'b0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_spec      <= 1'b0;
            r_spec_res  <= '0;
            r_spec_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign     <= bus.a[31];
                        r_mag      <= {8'd0, w_m};
                        r_count    <= w_count;
                        r_left     <= w_dir_left;
                        r_guard    <= 1'b0;
                        r_sticky   <= 1'b0;
                        r_spec     <= w_spec;
                        r_spec_res <= w_spec_res;
                        r_spec_ovf <= w_is_nan || w_is_inf || w_is_ovf;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_count != 5'd0) begin
                        if (r_left) begin
                            r_mag <= r_mag << 1;
                        end else begin
                            r_mag    <= r_mag >> 1;
                            r_guard  <= r_mag[0];
                            r_sticky <= r_sticky || r_guard;
                        end
                        r_count <= r_count - 5'd1;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_spec) begin
                        r_res <= r_spec_res;
                        r_ovf <= r_spec_ovf;
                    end else begin
                        r_res <= w_signed;
                        r_ovf <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_ftoi.sv
// Self-checking bench for ftoi: vector table with a
// result scoreboard plus handshake and reset sequences.
module tb_ftoi;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;

    ftoi_if bus ();

    ftoi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Accepts one operand and waits for its result; leaves
    // the result unconsumed.  Returns the observed latency.
    task automatic issue(input logic [31:0] a,
                         input exp_t e,
                         output int lat);
        int  w;
        bit  got;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) got = 1'b1;
        end
    endtask

    task automatic check_result(input string nm, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_lat"}, 32'(lat), 32'(e.lat));
        chk({nm, "_res"}, bus.res, e.res);
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_take", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] r,
                       input logic o, input int l);
        vec_t v;
        v.a   = a;
        v.res = r;
        v.ovf = o;
        v.lat = l;
        vecs.push_back(v);
    endtask

    initial begin
        int   lat;
        exp_t e;
        bit   stale;
        logic [31:0] held;

        n_tests = 0;
        n_fail  = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;

        add(32'h3FC0_0000, 32'h0000_0002, 1'b0, 25);
        add(32'h4020_0000, 32'h0000_0002, 1'b0, 24);
        add(32'hC060_0000, 32'hFFFF_FFFC, 1'b0, 24);
        add(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 9);
        add(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2);
        add(32'hCF00_0000, 32'h8000_0000, 1'b0, 2);
        add(32'hCF00_0001, 32'h8000_0000, 1'b1, 2);
        add(32'h7FC0_0000, 32'h8000_0000, 1'b1, 2);
        add(32'hFF80_0000, 32'h8000_0000, 1'b1, 2);
        add(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 2);
        add(32'h3F00_0000, 32'h0000_0000, 1'b0, 26);
        add(32'h3F40_0000, 32'h0000_0001, 1'b0, 26);
        add(32'h0000_0001, 32'h0000_0000, 1'b0, 27);
        add(32'h0000_0000, 32'h0000_0000, 1'b0, 27);
        add(32'h8000_0000, 32'h0000_0000, 1'b0, 27);
        add(32'h4B00_0000, 32'h0080_0000, 1'b0, 2);
        add(32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 19);
        add(32'h3FE0_0000, 32'h0000_0002, 1'b0, 25);
        add(32'h4E80_0000, 32'h4000_0000, 1'b0, 9);
        add(32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 26);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", bus.res, 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            e.res = vecs[i].res;
            e.ovf = vecs[i].ovf;
            e.lat = vecs[i].lat;
            issue(vecs[i].a, e, lat);
            check_result($sformatf("vec%0d", i), lat);
            consume();
        end

        // Backpressure: result held while out_ready is low
        e.res = 32'h0000_0002;
        e.ovf = 1'b0;
        e.lat = 24;
        issue(32'h4020_0000, e, lat);
        check_result("bp", lat);
        held = bus.res;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_res_stable", bus.res, 32'h0000_0002);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("bp_res_unchanged", bus.res, held);
        consume();

        // Reset in the middle of SHIFT
        @(negedge clk);
        bus.a        = 32'h3FC0_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("abort_accepted", 32'(bus.in_ready), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", 32'(stale), 32'd0);

        // Reset wins over a same-cycle accept
        @(negedge clk);
        rst          = 1'b1;
        bus.a        = 32'h3FC0_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rstacc_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rstacc_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        stale = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("rstacc_no_result", 32'(stale), 32'd0);

        // Recovery after the aborted operations
        e.res = 32'hFFFF_FFFC;
        e.ovf = 1'b0;
        e.lat = 24;
        issue(32'hC060_0000, e, lat);
        check_result("recover", lat);
        consume();

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
